// File: rtl/arith_seq_if.sv
// Command and result handshake bundle for arith_seq.
// master = command producer / result consumer, slave = arith_seq.
interface arith_seq_if #(
   parameter int WIDTH = 32
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic             cmd_src;
   logic [WIDTH-1:0] cmd_a;
   logic [WIDTH-1:0] cmd_b;
   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] res_data;

   modport master (
      output cmd_valid, cmd_op, cmd_src, cmd_a, cmd_b, res_ready,
      input  cmd_ready, res_valid, res_data
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_src, cmd_a, cmd_b, res_ready,
      output cmd_ready, res_valid, res_data
   );
endinterface

// File: rtl/arith_seq.sv
// arith_seq: operand front-end and result stage around a combinational add/sub unit.
// Result flags are generated only when ARITH_SEQ_FLAGS_EN is defined; otherwise tied to 0.
module arith_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   arith_seq_if.slave       bus,
   output logic             alu_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_y,
   output logic [WIDTH-1:0] acc,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_v
);
   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
   typedef enum logic [1:0] {
      OP_LOAD  = 2'b00,
      OP_ADD   = 2'b01,
      OP_SUB   = 2'b10,
      OP_CLEAR = 2'b11
   } op_t;

   state_t           state, state_nxt;
   op_t              op_q;
   logic             accept, exec;
   logic [WIDTH-1:0] r, res_q;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // cmd_ready is masked by reset so nothing is offered while reset is held
   always_comb begin
      state_nxt     = state;
      bus.cmd_ready = 1'b0;
      bus.res_valid = 1'b0;
      accept        = 1'b0;
      exec          = 1'b0;
      case (state)
         IDLE: begin
            bus.cmd_ready = !reset;
            accept        = bus.cmd_valid && !reset;
            if (accept) state_nxt = EXEC;
         end
         EXEC: begin
            exec      = 1'b1;
            state_nxt = DONE;
         end
         DONE: begin
            bus.res_valid = 1'b1;
            if (bus.res_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      r = '0;
      case (op_q)
         OP_ADD, OP_SUB: r = alu_y;
         OP_LOAD:        r = alu_b;
         OP_CLEAR:       r = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         alu_a  <= '0;
         alu_b  <= '0;
         alu_op <= 1'b0;
         op_q   <= OP_LOAD;
         acc    <= '0;
         res_q  <= '0;
      end else begin
         if (accept) begin
            alu_a  <= bus.cmd_src ? acc : bus.cmd_a;
            alu_b  <= bus.cmd_b;
            alu_op <= (bus.cmd_op == OP_SUB);
            op_q   <= op_t'(bus.cmd_op);
         end
         if (exec) begin
            acc   <= r;
            res_q <= r;
         end
      end
   end

   assign bus.res_data = res_q;

`ifdef ARITH_SEQ_FLAGS_EN
   logic fz, fn, fv, v_nxt;

   always_comb begin
      v_nxt = 1'b0;
      case (op_q)
         OP_ADD:  v_nxt = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (r[WIDTH-1] != alu_a[WIDTH-1]);
         OP_SUB:  v_nxt = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (r[WIDTH-1] != alu_a[WIDTH-1]);
         default: v_nxt = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fz <= 1'b0;
         fn <= 1'b0;
         fv <= 1'b0;
      end else if (exec) begin
         fz <= (r == '0);
         fn <= r[WIDTH-1];
         fv <= v_nxt;
      end
   end

   assign flag_z = fz;
   assign flag_n = fn;
   assign flag_v = fv;
`else
   assign flag_z = 1'b0;
   assign flag_n = 1'b0;
   assign flag_v = 1'b0;
`endif
endmodule
